// File: rtl/uio_bus_sched_pkg.sv
// -----------------------------------------------------------------------------
// tt_uio_pkg
// Purpose : shared types and constants for the uio pad-bus scheduler.
// Contents: FSM state enum, bus direction encodings, pad output-enable
//           patterns, and a small integer max helper for parameter maths.
// -----------------------------------------------------------------------------
package tt_uio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } st_e;

    localparam logic       DIR_IN  = 1'b0;
    localparam logic       DIR_OUT = 1'b1;

    localparam logic [7:0] OE_IN   = 8'h00;
    localparam logic [7:0] OE_OUT  = 8'hFF;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uio_bus_sched_if.sv
// -----------------------------------------------------------------------------
// uio_bus_sched_if
// Purpose : bundles the requester handshake and the uio pad signals of the
//           scheduler.
// Signals : ena, req_valid, req_dir, req_wdata, uio_in   (core/pads -> sched)
//           req_ready, rsp_rdata, uio_out, uio_oe, busy  (sched -> core/pads)
// Modports: slave  - the scheduler
//           master - the core logic / pad side driving requests
// -----------------------------------------------------------------------------
interface uio_bus_sched_if #(
    parameter int N_REQ = 2
) ();
    logic                 ena;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_dir;
    logic [8*N_REQ-1:0]   req_wdata;
    logic [N_REQ-1:0]     req_ready;
    logic [7:0]           rsp_rdata;
    logic [7:0]           uio_in;
    logic [7:0]           uio_out;
    logic [7:0]           uio_oe;
    logic                 busy;

    modport slave (
        input  ena, req_valid, req_dir, req_wdata, uio_in,
        output req_ready, rsp_rdata, uio_out, uio_oe, busy
    );

    modport master (
        output ena, req_valid, req_dir, req_wdata, uio_in,
        input  req_ready, rsp_rdata, uio_out, uio_oe, busy
    );
endinterface

// File: rtl/uio_bus_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purpose : combinational round-robin picker. Returns the first valid
//           requester at or after i_rr_ptr, wrapping modulo N_REQ.
// Ports   : i_req_valid [N_REQ] pending requests
//           i_rr_ptr    [PW]    highest-priority index
//           o_gnt_idx   [PW]    chosen requester
//           o_gnt_any           at least one request pending
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [PW-1:0]    i_rr_ptr,
    output logic [PW-1:0]    o_gnt_idx,
    output logic             o_gnt_any
);

    logic [PW-1:0] w_cand;

    // Walk from the farthest offset down to offset 0 so the candidate
    // closest to the pointer is the last (winning) assignment.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = PW'((int'(i_rr_ptr) + k) % N_REQ);
            if (i_req_valid[w_cand]) begin
                o_gnt_idx = w_cand;
                o_gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_sched.sv
// -----------------------------------------------------------------------------
// uio_bus_sched
// Purpose : shares the 8-bit bidirectional uio pad bus between N_REQ
//           requesters with round-robin grants; inserts a released-bus
//           turnaround only when the bus changes direction.
// Ports   : clk   system clock, rising edge
//           rst_n asynchronous active-low reset
//           bus   uio_bus_sched_if.slave (requests, ready/rdata, pads, busy)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for ena && any req_valid; bus stays parked
// TURN  | direction change, uio_oe released for TURN_CYCLES
// XFER  | drive write data / hold bus before sampling, HOLD_CYCLES
// DONE  | one-cycle req_ready pulse, advance round-robin pointer
// -----------------------------------------------------------------------------
module uio_bus_sched
    import tt_uio_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    uio_bus_sched_if.slave  bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(imax(TURN_CYCLES, HOLD_CYCLES) + 1);

    st_e              r_state;
    st_e              w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [PW-1:0]    r_idx;
    logic             r_dir;
    logic [7:0]       r_wdata;
    logic             r_last_dir;
    logic [PW-1:0]    r_rr_ptr;
    logic [7:0]       r_oe;
    logic [7:0]       r_out;
    logic [N_REQ-1:0] r_ready;
    logic [7:0]       r_rdata;

    logic [PW-1:0]    w_gnt_idx;
    logic             w_gnt_any;
    logic             w_gnt_dir;
    logic [7:0]       w_gnt_wdata;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .i_req_valid (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_any   (w_gnt_any)
    );

    assign w_gnt_dir   = bus.req_dir[w_gnt_idx];
    assign w_gnt_wdata = bus.req_wdata[{w_gnt_idx, 3'b000} +: 8];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!bus.ena) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        if (w_gnt_dir != r_last_dir) begin
                            w_state_nxt = TURN;
                            w_cnt_nxt   = CW'(TURN_CYCLES - 1);
                        end else begin
                            w_state_nxt = XFER;
                            w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
                        end
                    end
                end
                TURN: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = XFER;
                        w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                XFER: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                DONE: w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_dir      <= DIR_IN;
            r_wdata    <= 8'h00;
            r_last_dir <= DIR_IN;
            r_rr_ptr   <= '0;
            r_oe       <= OE_IN;
            r_out      <= 8'h00;
            r_ready    <= '0;
            r_rdata    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= '0;
            if (!bus.ena) begin
                // Abort: park as input; pointer untouched so the same
                // requester wins again.
                r_oe       <= OE_IN;
                r_last_dir <= DIR_IN;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_gnt_any) begin
                            r_idx   <= w_gnt_idx;
                            r_dir   <= w_gnt_dir;
                            r_wdata <= w_gnt_wdata;
                            if (w_gnt_dir != r_last_dir) begin
                                r_oe <= OE_IN;
                            end else if (w_gnt_dir == DIR_OUT) begin
                                r_oe  <= OE_OUT;
                                r_out <= w_gnt_wdata;
                            end
                        end
                    end
                    TURN: begin
                        if (r_cnt == '0) begin
                            r_last_dir <= r_dir;
                            if (r_dir == DIR_OUT) begin
                                r_oe  <= OE_OUT;
                                r_out <= r_wdata;
                            end
                        end
                    end
                    XFER: begin
                        if (r_cnt == '0) begin
                            if (r_dir == DIR_IN) begin
                                r_rdata <= bus.uio_in;
                            end
                            r_ready[r_idx] <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_rr_ptr <= (r_idx == PW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.uio_oe    = r_oe;
    assign bus.uio_out   = r_out;
    assign bus.req_ready = r_ready;
    assign bus.rsp_rdata = r_rdata;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uio_bus_sched.sv
// -----------------------------------------------------------------------------
// tb_uio_bus_sched
// Purpose : self-checking bench for uio_bus_sched. A transaction-level model
//           predicts grant order, ready cycle and data for each batch of
//           requests and queues the expectations; a monitor pops and compares
//           on every req_ready pulse.
// -----------------------------------------------------------------------------
module tb_uio_bus_sched;
    import tt_uio_pkg::*;

    localparam int N = 2;
    localparam int T = 1;
    localparam int H = 2;

    typedef struct {
        int         idx;
        logic       dir;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    exp_t sbq[$];

    int         b_rem [N];
    logic       b_dir [N];
    logic [7:0] b_wd  [N];
    logic [7:0] b_rd;
    int         m_ptr = 0;
    logic       m_last = DIR_IN;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uio_bus_sched_if #(.N_REQ(N)) bus ();

    uio_bus_sched #(
        .N_REQ       (N),
        .TURN_CYCLES (T),
        .HOLD_CYCLES (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: arbitration and latency from the rules, one transfer at a time.
    task automatic model_batch(input int t0);
        int rem [N];
        int t;
        int g;
        int lat;
        exp_t e;
        t = t0;
        for (int i = 0; i < N; i++) rem[i] = b_rem[i];
        for (int n = 0; n < 64; n++) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && rem[c] > 0) g = c;
            end
            if (g < 0) break;
            lat    = 1 + H + ((b_dir[g] != m_last) ? T : 0);
            e.idx  = g;
            e.dir  = b_dir[g];
            e.data = (b_dir[g] == DIR_OUT) ? b_wd[g] : b_rd;
            e.cyc  = t + lat;
            sbq.push_back(e);
            t      = t + lat + 1;
            m_last = b_dir[g];
            m_ptr  = (g + 1) % N;
            rem[g]--;
        end
    endtask

    task automatic start_batch();
        for (int i = 0; i < N; i++) begin
            bus.req_dir[i]           = b_dir[i];
            bus.req_wdata[i*8 +: 8]  = b_wd[i];
            bus.req_valid[i]         = (b_rem[i] > 0);
        end
        bus.uio_in = b_rd;
        model_batch(cyc);
    endtask

    // Requesters keep valid high until their last ready pulse.
    task automatic drain_batch();
        int r [N];
        int left;
        int n;
        for (int i = 0; i < N; i++) r[i] = b_rem[i];
        left = 0;
        for (int i = 0; i < N; i++) left += r[i];
        n = 0;
        while (left > 0 && n < 200) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i] && r[i] > 0) begin
                    r[i]--;
                    if (r[i] == 0) bus.req_valid[i] = 1'b0;
                end
            end
            left = 0;
            for (int i = 0; i < N; i++) left += r[i];
        end
        check("batch_drain_left", 32'(left), 32'd0);
    endtask

    // Monitor: every ready pulse is matched against the next expectation.
    always @(negedge clk) begin
        if (bus.req_ready != '0) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", 32'(bus.req_ready), 32'd0);
            end else begin
                exp_t e;
                logic [N-1:0] oh;
                e  = sbq.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                check("ready_onehot", 32'(bus.req_ready), 32'(oh));
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                if (e.dir == DIR_IN) begin
                    check("read_rdata", 32'(bus.rsp_rdata), 32'(e.data));
                    check("read_oe", 32'(bus.uio_oe), 32'(OE_IN));
                end else begin
                    check("write_oe", 32'(bus.uio_oe), 32'(OE_OUT));
                    check("write_out", 32'(bus.uio_out), 32'(e.data));
                end
            end
        end
    end

    initial begin
        bus.ena       = 1'b1;
        bus.req_valid = '0;
        bus.req_dir   = '0;
        bus.req_wdata = '0;
        bus.uio_in    = 8'h00;
        for (int i = 0; i < N; i++) begin
            b_rem[i] = 0;
            b_dir[i] = DIR_IN;
            b_wd[i]  = 8'h00;
        end
        b_rd = 8'h00;

        // Reset values
        @(negedge clk);
        check("rst_oe", 32'(bus.uio_oe), 32'h00);
        check("rst_out", 32'(bus.uio_out), 32'h00);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset in the middle of a write XFER
        @(negedge clk);
        bus.req_dir[0]        = DIR_OUT;
        bus.req_wdata[7:0]    = 8'h5A;
        bus.req_valid[0]      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_oe", 32'(bus.uio_oe), 32'hFF);
        check("pre_rst_out", 32'(bus.uio_out), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_oe", 32'(bus.uio_oe), 32'h00);
        check("async_rst_out", 32'(bus.uio_out), 32'h00);
        check("async_rst_busy", 32'(bus.busy), 32'h0);
        check("async_rst_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // First write: TURN, two drive cycles, ready, parked as output
        @(negedge clk);
        b_rem[0] = 1; b_rem[1] = 0;
        b_dir[0] = DIR_OUT; b_wd[0] = 8'hA5;
        start_batch();
        fork
            drain_batch();
            begin
                @(negedge clk);
                check("w1_turn_oe", 32'(bus.uio_oe), 32'h00);
                check("w1_turn_busy", 32'(bus.busy), 32'h1);
                @(negedge clk);
                check("w1_x1_oe", 32'(bus.uio_oe), 32'hFF);
                check("w1_x1_out", 32'(bus.uio_out), 32'hA5);
                @(negedge clk);
                check("w1_x2_oe", 32'(bus.uio_oe), 32'hFF);
                @(negedge clk);
                @(negedge clk);
                check("w1_park_oe", 32'(bus.uio_oe), 32'hFF);
                check("w1_park_busy", 32'(bus.busy), 32'h0);
            end
        join

        // Fairness: both write, two transfers each
        @(negedge clk);
        b_rem[0] = 2; b_rem[1] = 2;
        b_dir[0] = DIR_OUT; b_dir[1] = DIR_OUT;
        b_wd[0] = 8'h11; b_wd[1] = 8'h22;
        start_batch();
        drain_batch();

        // Read after write
        @(negedge clk);
        b_rem[0] = 0; b_rem[1] = 1;
        b_dir[1] = DIR_IN; b_rd = 8'h3C;
        start_batch();
        fork
            drain_batch();
            begin
                @(negedge clk);
                check("rd_turn_oe", 32'(bus.uio_oe), 32'h00);
                @(negedge clk);
                check("rd_xfer_oe", 32'(bus.uio_oe), 32'h00);
                check("rd_xfer_busy", 32'(bus.busy), 32'h1);
            end
        join

        // Abort during write XFER, then re-grant of the same requester
        @(negedge clk);
        bus.req_valid       = '0;
        bus.req_dir[0]      = DIR_OUT;
        bus.req_wdata[7:0]  = 8'h77;
        bus.req_valid[0]    = 1'b1;
        @(negedge clk);
        check("ab_turn_oe", 32'(bus.uio_oe), 32'h00);
        @(negedge clk);
        check("ab_xfer_oe", 32'(bus.uio_oe), 32'hFF);
        bus.ena = 1'b0;
        @(negedge clk);
        check("ab_oe", 32'(bus.uio_oe), 32'h00);
        check("ab_busy", 32'(bus.busy), 32'h0);
        bus.ena  = 1'b1;
        m_last   = DIR_IN;
        b_rem[0] = 1; b_rem[1] = 0;
        b_dir[0] = DIR_OUT; b_wd[0] = 8'h77;
        model_batch(cyc);
        @(negedge clk);
        check("ab_regrant_turn_oe", 32'(bus.uio_oe), 32'h00);
        check("ab_regrant_busy", 32'(bus.busy), 32'h1);
        drain_batch();

        // Late drop: valid and wdata change after the grant
        @(negedge clk);
        b_rem[0] = 0; b_rem[1] = 1;
        b_dir[1] = DIR_OUT; b_wd[1] = 8'h9C;
        start_batch();
        @(negedge clk);
        bus.req_valid[1]    = 1'b0;
        bus.req_wdata[15:8] = 8'h63;
        drain_batch();

        // Randomized batches
        for (int it = 0; it < 12; it++) begin
            int tot;
            @(negedge clk);
            check("idle_before_batch", 32'(bus.busy), 32'h0);
            tot = 0;
            for (int i = 0; i < N; i++) begin
                b_rem[i] = $urandom_range(0, 2);
                b_dir[i] = 1'($urandom_range(0, 1));
                b_wd[i]  = 8'($urandom_range(0, 255));
                tot += b_rem[i];
            end
            if (tot == 0) b_rem[$urandom_range(0, N-1)] = 1;
            b_rd = 8'($urandom_range(0, 255));
            start_batch();
            drain_batch();
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
